// File: rtl/dfx_seq_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dfx_seq_engine : slot-table DFX sequencer with per-slot profiling, status,
//                  handshake timeout and graceful stop
// Revision 1.0
// ---------------------------------------------------------------------------
module dfx_seq_engine #(
  parameter int INDEX_WIDTH   = 3,
  parameter int ADDR_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 26,
  parameter int PROFILE_WIDTH = 32,
  parameter int LOOP_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cfg_wr_en,
  input  logic [INDEX_WIDTH-1:0]   i_cfg_wr_index,
  input  logic [1:0]               i_cfg_wr_field,
  input  logic [ADDR_WIDTH-1:0]    i_cfg_wr_data,
  input  logic [INDEX_WIDTH-1:0]   i_cfg_rd_index,
  output logic [PROFILE_WIDTH-1:0] o_cfg_rd_profile,
  output logic [1:0]               o_cfg_rd_status,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [INDEX_WIDTH-1:0]   i_end_cnt,
  input  logic [LOOP_WIDTH-1:0]    i_loop_cnt,
  input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [INDEX_WIDTH-1:0]   o_main_cnt,
  output logic                     o_slave_reprog,
  output logic                     o_slave_init,
  output logic                     o_slave_start_exec,
  input  logic                     i_slave_reprog_accept,
  input  logic                     i_slave_fin_init,
  input  logic                     i_slave_start_exec_accept,
  input  logic                     i_slave_fin_exec,
  output logic [ADDR_WIDTH-1:0]    o_slave_src_addr,
  output logic [ADDR_WIDTH-1:0]    o_slave_des_addr,
  output logic [SIZE_WIDTH-1:0]    o_slave_src_size,
  output logic [SIZE_WIDTH-1:0]    o_slave_des_size
);

  localparam int c_DEPTH = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_REPROG = 3'd2,
    S_INIT   = 3'd3,
    S_EXEC   = 3'd4,
    S_WAIT   = 3'd5,
    S_NEXT   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0]    r_src_addr_tbl [c_DEPTH];
  logic [ADDR_WIDTH-1:0]    r_des_addr_tbl [c_DEPTH];
  logic [SIZE_WIDTH-1:0]    r_src_size_tbl [c_DEPTH];
  logic [SIZE_WIDTH-1:0]    r_des_size_tbl [c_DEPTH];
  logic [PROFILE_WIDTH-1:0] r_prof_tbl     [c_DEPTH];
  logic [1:0]               r_stat_tbl     [c_DEPTH];

  logic [INDEX_WIDTH-1:0]   r_main;
  logic [INDEX_WIDTH-1:0]   r_end;
  logic [LOOP_WIDTH-1:0]    r_pass;
  logic [LOOP_WIDTH-1:0]    r_loop;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [TIMEOUT_WIDTH-1:0] r_wait;
  logic [PROFILE_WIDTH-1:0] r_prof;
  logic                     r_stop;
  logic                     r_done;
  logic                     r_error;
  logic [ADDR_WIDTH-1:0]    r_src_addr;
  logic [ADDR_WIDTH-1:0]    r_des_addr;
  logic [SIZE_WIDTH-1:0]    r_src_size;
  logic [SIZE_WIDTH-1:0]    r_des_size;

  logic                     w_resp;
  logic                     w_expire;
  logic                     w_hs_state;
  logic                     w_stop_pend;
  logic                     w_last_slot;
  logic                     w_pass_done;
  logic [PROFILE_WIDTH-1:0] w_prof_inc;

  assign w_hs_state  = (r_state == S_REPROG) || (r_state == S_INIT) ||
                       (r_state == S_EXEC)   || (r_state == S_WAIT);
  // A stop arriving in the NEXT cycle itself still ends the run there.
  assign w_stop_pend = r_stop || i_stop;
  assign w_last_slot = (r_main == r_end);
  assign w_pass_done = (r_loop != '0) && ((r_pass + LOOP_WIDTH'(1)) == r_loop);
  assign w_prof_inc  = (&r_prof) ? r_prof : r_prof + PROFILE_WIDTH'(1);

  always_comb begin
    w_next   = r_state;
    w_resp   = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD;
      S_LOAD:   w_next = S_REPROG;
      S_REPROG: begin
        w_resp = i_slave_reprog_accept;
        if (w_resp) w_next = S_INIT;
      end
      S_INIT: begin
        w_resp = i_slave_fin_init;
        if (w_resp) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_resp = i_slave_start_exec_accept;
        if (w_resp) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_resp = i_slave_fin_exec;
        if (w_resp) w_next = S_NEXT;
      end
      S_NEXT: begin
        if (w_stop_pend)                     w_next = S_IDLE;
        else if (!w_last_slot || !w_pass_done) w_next = S_LOAD;
        else                                 w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    if (w_hs_state && !w_resp && (r_timeout != '0) &&
        (r_wait == r_timeout - TIMEOUT_WIDTH'(1))) begin
      w_expire = 1'b1;
      w_next   = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < c_DEPTH; k++) begin
        r_src_addr_tbl[k] <= '0;
        r_des_addr_tbl[k] <= '0;
        r_src_size_tbl[k] <= '0;
        r_des_size_tbl[k] <= '0;
        r_prof_tbl[k]     <= '0;
        r_stat_tbl[k]     <= 2'b00;
      end
      r_main     <= '0;
      r_end      <= '0;
      r_pass     <= '0;
      r_loop     <= '0;
      r_timeout  <= '0;
      r_wait     <= '0;
      r_prof     <= '0;
      r_stop     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_src_addr <= '0;
      r_des_addr <= '0;
      r_src_size <= '0;
      r_des_size <= '0;
    end else begin
      r_done <= (r_state != S_IDLE) && (w_next == S_IDLE);
      r_wait <= (w_next != r_state) ? '0 : r_wait + TIMEOUT_WIDTH'(1);
      if ((r_state != S_IDLE) && i_stop) r_stop <= 1'b1;
      if (w_next == S_IDLE)              r_stop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_wr_en) begin
            case (i_cfg_wr_field)
              2'd0:    r_src_addr_tbl[i_cfg_wr_index] <= i_cfg_wr_data;
              2'd1:    r_src_size_tbl[i_cfg_wr_index] <= i_cfg_wr_data[SIZE_WIDTH-1:0];
              2'd2:    r_des_addr_tbl[i_cfg_wr_index] <= i_cfg_wr_data;
              default: r_des_size_tbl[i_cfg_wr_index] <= i_cfg_wr_data[SIZE_WIDTH-1:0];
            endcase
          end
          if (i_start) begin
            r_main    <= '0;
            r_pass    <= '0;
            r_error   <= 1'b0;
            r_end     <= i_end_cnt;
            r_loop    <= i_loop_cnt;
            r_timeout <= i_timeout;
            for (int k = 0; k < c_DEPTH; k++) r_stat_tbl[k] <= 2'b00;
          end
        end
        S_LOAD: begin
          r_src_addr         <= r_src_addr_tbl[r_main];
          r_des_addr         <= r_des_addr_tbl[r_main];
          r_src_size         <= r_src_size_tbl[r_main];
          r_des_size         <= r_des_size_tbl[r_main];
          r_stat_tbl[r_main] <= 2'b01;
          r_prof             <= '0;
        end
        S_REPROG, S_INIT, S_EXEC, S_WAIT: begin
          r_prof <= w_prof_inc;
          if (w_expire) begin
            r_stat_tbl[r_main] <= 2'b11;
            r_error            <= 1'b1;
          end else if ((r_state == S_WAIT) && i_slave_fin_exec) begin
            r_prof_tbl[r_main] <= w_prof_inc;
            r_stat_tbl[r_main] <= 2'b10;
          end
        end
        S_NEXT: begin
          if (w_next == S_LOAD) begin
            if (w_last_slot) begin
              r_main <= '0;
              r_pass <= r_pass + LOOP_WIDTH'(1);
            end else begin
              r_main <= r_main + INDEX_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy             = (r_state != S_IDLE);
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_main_cnt         = r_main;
  assign o_slave_reprog     = (r_state == S_REPROG);
  assign o_slave_init       = (r_state == S_INIT);
  assign o_slave_start_exec = (r_state == S_EXEC);
  assign o_slave_src_addr   = r_src_addr;
  assign o_slave_des_addr   = r_des_addr;
  assign o_slave_src_size   = r_src_size;
  assign o_slave_des_size   = r_des_size;
  assign o_cfg_rd_profile   = r_prof_tbl[i_cfg_rd_index];
  assign o_cfg_rd_status    = r_stat_tbl[i_cfg_rd_index];

endmodule
`default_nettype wire
